pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Fetch-stage PC holder and instruction-fetch requester. It sits between the PC-select logic and the instruction SRAM-like port. It consumes pc_nextF, owns the architectural fetch PC (pcF), issues one outstanding instruction request at a time, and delivers pcF/instrF with a valid flag to the decode stage. It also handles pipeline stalls and exception/eret flush redirects, including discarding a cancelled in-flight fetch.

Parameters:
RESET_PC, 32'hbfc00000, fetch address after reset
ADDR_W, 32, address/data width (fixed 32; parameter for documentation only)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
pc_nextF  input  32  next PC from PC-select logic (jump > branch > pc+4)
stallF  input  1  downstream cannot accept instruction this cycle
flushF  input  1  exception/eret redirect, highest priority
flush_pcF  input  32  redirect target when flushF=1
inst_req  output  1  fetch request valid
inst_addr  output  32  fetch address (= pcF)
inst_addr_ok  input  1  address accepted this cycle (handshake with inst_req)
inst_data_ok  input  1  read data returned this cycle
inst_rdata  input  32  returned instruction word
pcF  output  32  PC of current fetch / delivered instruction
instrF  output  32  delivered instruction
instr_validF  output  1  instrF/pcF valid for decode
fetch_busyF  output  1  = ~instr_validF; to hazard unit

Behaviour:
- States: S_REQ, S_WAIT, S_VALID, S_DISCARD. At most one outstanding request.
- Reset (rst=1 at edge): state=S_REQ, pcF=RESET_PC, instrF=0, instr_validF=0. The first cycle after reset drives inst_req=1 with inst_addr=RESET_PC.
- inst_req = (state==S_REQ). inst_addr = pcF always. instr_validF = (state==S_VALID).
- S_REQ: when addr_ok=1, go to S_WAIT. Otherwise hold. inst_addr may change only via flush while addr_ok=0.
- S_WAIT: when data_ok=1, instrF<=inst_rdata and go to S_VALID. instr_validF rises the cycle after data_ok. Minimum latency is 2 cycles: addr_ok at N, data_ok at N+1, valid at N+2.
- S_VALID: advance = ~stallF. On advance, pcF<=pc_nextF and go to S_REQ. If stallF=1, hold pcF, instrF and valid indefinitely.
- S_DISCARD: wait for data_ok of the cancelled request, drop inst_rdata, then go to S_REQ. No inst_req is driven in this state.
- Flush rules (flushF=1 overrides everything; pcF<=flush_pcF in all cases):
  - S_REQ with addr_ok=0: go to S_REQ (request withdrawn, new address next cycle).
  - S_REQ with addr_ok=1: go to S_DISCARD.
  - S_WAIT with data_ok=0: go to S_DISCARD.
  - S_WAIT with data_ok=1: drop data, go to S_REQ.
  - S_VALID: drop instruction, go to S_REQ. stallF is ignored.
  - S_DISCARD with data_ok=0: stay in S_DISCARD.
  - S_DISCARD with data_ok=1: go to S_REQ.
- Flushed or discarded data never appears with instr_validF=1.
- Branch delay slot: pc_nextF is sampled only on advance. The delay slot is therefore fetched naturally before the redirect target. Redirects from branch/jump never cancel a fetch.
- Reset mid-operation: returns to the reset state immediately. Any late data_ok after reset is ignored while in S_REQ (the memory side is reset together with this block).
- inst_data_ok in S_REQ or S_VALID is a protocol error; ignore it, no state change.
- pcF wraps modulo 2^32 with no special handling. Alignment is not checked here.

Decomposition:
- Shared defines header: state encodings (2-bit S_REQ=0, S_WAIT=1, S_VALID=2, S_DISCARD=3) and the default RESET_PC constant, so the hazard unit and bench can decode state.
- Single module. No sub-module is natural; the next-state logic and PC/instr registers stay in one always block pair.

Test Plan:
- Reset, then memory with addr_ok the same cycle and data_ok one cycle later, stallF=0 -> inst_addr sequence bfc00000, bfc00004, bfc00008; each instr_validF pulse carries the matching pcF/instrF.
- stallF=1 for 5 cycles while in S_VALID -> pcF, instrF and instr_validF held constant; no inst_req; advance occurs on the first cycle with stallF=0.
- pc_nextF=0x80001000 at advance (jump) -> next inst_addr=0x80001000 with exactly one request.
- flushF with flush_pcF=0xbfc00380 one cycle after addr_ok, data_ok 3 cycles later -> returned word dropped, instr_validF stays 0, next inst_req addr=0xbfc00380.
- flushF coincident with data_ok in S_WAIT, and flushF with addr_ok in S_REQ -> respectively S_REQ next cycle, and S_DISCARD then one request to flush_pcF after data_ok.
- rst asserted while in S_WAIT -> next cycle inst_req=1, addr=RESET_PC, instr_validF=0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared fetch-stage state encodings and the default reset PC.
//               The hazard unit and the testbench use these to decode state.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_VALID   = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] c_reset_pc_default = 32'hbfc0_0000;

endpackage : pc_fetch_unit_pkg
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Instruction-fetch request/response bus between the fetch unit
//               (master) and the instruction SRAM-like port (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [ADDR_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface : pc_fetch_unit_if
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Fetch PC holder and single-outstanding instruction requester
//               with stall handling and flush redirect / in-flight discard.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc_default,
    parameter int          ADDR_W   = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [ADDR_W-1:0] pc_nextF,
    input  wire logic              stallF,
    input  wire logic              flushF,
    input  wire logic [ADDR_W-1:0] flush_pcF,
    pc_fetch_unit_if.master        inst_bus,
    output logic      [ADDR_W-1:0] pcF,
    output logic      [ADDR_W-1:0] instrF,
    output logic                   instr_validF,
    output logic                   fetch_busyF
);

    fetch_state_t      r_state_q, w_state_d;
    logic [ADDR_W-1:0] r_pc_q,    w_pc_d;
    logic [ADDR_W-1:0] r_instr_q, w_instr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_REQ;
            r_pc_q    <= RESET_PC[ADDR_W-1:0];
            r_instr_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;

        case (r_state_q)
            S_REQ: begin
                if (flushF) begin
                    // An accepted request is still owed a data beat; swallow it.
                    w_pc_d    = flush_pcF;
                    w_state_d = inst_bus.inst_addr_ok ? S_DISCARD : S_REQ;
                end else if (inst_bus.inst_addr_ok) begin
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flushF) begin
                    w_pc_d    = flush_pcF;
                    w_state_d = inst_bus.inst_data_ok ? S_REQ : S_DISCARD;
                end else if (inst_bus.inst_data_ok) begin
                    w_instr_d = inst_bus.inst_rdata;
                    w_state_d = S_VALID;
                end
            end
            S_VALID: begin
                // pc_nextF is only consumed here, so the delay slot is fetched first.
                if (flushF) begin
                    w_pc_d    = flush_pcF;
                    w_state_d = S_REQ;
                end else if (!stallF) begin
                    w_pc_d    = pc_nextF;
                    w_state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (flushF) begin
                    w_pc_d = flush_pcF;
                end
                if (inst_bus.inst_data_ok) begin
                    w_state_d = S_REQ;
                end
            end
            default: begin
                w_state_d = S_REQ;
            end
        endcase
    end

    assign inst_bus.inst_req  = (r_state_q == S_REQ);
    assign inst_bus.inst_addr = r_pc_q;
    assign pcF                = r_pc_q;
    assign instrF             = r_instr_q;
    assign instr_validF       = (r_state_q == S_VALID);
    assign fetch_busyF        = ~instr_validF;

endmodule : pc_fetch_unit
`default_nettype wire
